// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit path.
// The receive deserializer is expected to reuse these.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bit positions of the frame-format fields in the bridge Cntrl register.
    localparam int CNTRL_TX_EN      = 0;
    localparam int CNTRL_PARITY_EN  = 1;
    localparam int CNTRL_PARITY_ODD = 2;
    localparam int CNTRL_TWO_STOP   = 3;

    localparam int DEF_BAUD_WIDTH = 20;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the TX FIFO (master) and the serializer (slave).
interface uart_tx_serializer_if #(parameter int DATA_WIDTH = 8);
    import uart_tx_serializer_pkg::*;

    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;

    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer_baud_gen.sv
// Loadable baud down-counter; bit_end is high on the last cycle of a bit.
// Shared by the TX serializer and the RX deserializer.
module uart_baud_gen
    import uart_tx_serializer_pkg::*;
#(
    parameter int BAUD_WIDTH = DEF_BAUD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BAUD_WIDTH-1:0] period,
    output logic                  bit_end
);
    logic [BAUD_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= period;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign bit_end = (cnt == '0);
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out
// start, data (LSB first), optional parity and 1 or 2 stop bits on TXD.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_WIDTH = DEF_BAUD_WIDTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  tx_en,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic [BAUD_WIDTH-1:0] baud_div,
    uart_tx_serializer_if.slave   fifo,
    output logic                  TXD,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state, state_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic [IW-1:0]         bit_idx, bit_idx_nxt;
    logic                  stop_idx, stop_idx_nxt;
    logic [BAUD_WIDTH-1:0] baud_q, period;
    logic                  par_en_q, two_stop_q, par_bit;
    logic                  txd_q, txd_nxt, done_q, done_nxt;
    logic                  bit_end, load, last_stop, accept;

    uart_baud_gen #(.BAUD_WIDTH(BAUD_WIDTH)) u_baud (
        .clk     (PCLK),
        .rst     (PRESET),
        .load    (load),
        .period  (period),
        .bit_end (bit_end)
    );

    // Refill window: idle, or the final cycle of the final stop bit so
    // back-to-back frames leave no idle gap on the line.
    assign last_stop     = (state == ST_STOP) & bit_end & (stop_idx == two_stop_q);
    assign fifo.tx_ready = tx_en & ((state == ST_IDLE) | last_stop);
    assign accept        = fifo.tx_valid & fifo.tx_ready;
    assign period        = accept ? baud_div : baud_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            baud_q     <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            state    <= state_nxt;
            txd_q    <= txd_nxt;
            done_q   <= done_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_idx <= stop_idx_nxt;
            if (accept) begin
                // Frame format is frozen here for the whole frame.
                shift      <= fifo.tx_data;
                baud_q     <= baud_div;
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                par_bit    <= (^fifo.tx_data) ^ parity_odd;
            end else begin
                shift <= shift_nxt;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        txd_nxt      = txd_q;
        done_nxt     = 1'b0;
        load         = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (accept) begin
                    state_nxt = ST_START;
                    txd_nxt   = 1'b0;
                    load      = 1'b1;
                end
            end
            ST_START: if (bit_end) begin
                state_nxt   = ST_DATA;
                bit_idx_nxt = '0;
                txd_nxt     = shift[0];
                load        = 1'b1;
            end
            ST_DATA: if (bit_end) begin
                load = 1'b1;
                if (bit_idx == IW'(DATA_WIDTH - 1)) begin
                    stop_idx_nxt = 1'b0;
                    if (par_en_q) begin
                        state_nxt = ST_PARITY;
                        txd_nxt   = par_bit;
                    end else begin
                        state_nxt = ST_STOP;
                        txd_nxt   = 1'b1;
                    end
                end else begin
                    bit_idx_nxt = bit_idx + 1'b1;
                    shift_nxt   = shift >> 1;
                    txd_nxt     = shift_nxt[0];
                end
            end
            ST_PARITY: if (bit_end) begin
                state_nxt    = ST_STOP;
                stop_idx_nxt = 1'b0;
                txd_nxt      = 1'b1;
                load         = 1'b1;
            end
            ST_STOP: if (bit_end) begin
                if (last_stop) begin
                    done_nxt = 1'b1;
                    if (accept) begin
                        state_nxt = ST_START;
                        txd_nxt   = 1'b0;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        txd_nxt   = 1'b1;
                    end
                end else begin
                    stop_idx_nxt = 1'b1;
                    load         = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    assign TXD     = txd_q;
    assign tx_busy = (state != ST_IDLE);
    assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: per-cycle logs captured on the
// falling edge, frames checked against hand-written bit patterns.
module tb_uart_tx_serializer;
    localparam int DW  = 8;
    localparam int BW  = 20;
    localparam int LOG = 2048;

    logic          PCLK = 1'b0, PRESET = 1'b1;
    logic          tx_en = 1'b0, parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
    logic [BW-1:0] baud_div = '0;
    logic          TXD, tx_busy, tx_done;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(DW), .BAUD_WIDTH(BW)) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .tx_en      (tx_en),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .baud_div   (baud_div),
        .fifo       (bus),
        .TXD        (TXD),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 PCLK = ~PCLK;

    int   errs = 0, checks = 0, cyc = 0;
    logic txd_log [LOG];
    logic busy_log[LOG];
    logic done_log[LOG];
    logic rdy_log [LOG];
    int   acc_q[$], done_q[$];
    logic acc_pend = 1'b0;
    logic [7:0] fq[$];

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (cyc < LOG) begin
            txd_log[cyc]  = TXD;
            busy_log[cyc] = tx_busy;
            done_log[cyc] = tx_done;
            rdy_log[cyc]  = bus.tx_ready;
        end
        acc_pend = bus.tx_valid & bus.tx_ready;
        if (acc_pend) acc_q.push_back(cyc);
        if (tx_done === 1'b1) done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic upd();
        bus.tx_valid = (fq.size() != 0);
        bus.tx_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // FIFO model: pop the head after an edge that saw valid & ready.
    task automatic tick();
        @(posedge PCLK);
        #1;
        if (acc_pend && fq.size() != 0) void'(fq.pop_front());
        upd();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        upd();
    endtask

    task automatic clr();
        acc_q.delete();
        done_q.delete();
    endtask

    // bits[0] is the start bit; one entry per bit of the frame.
    task automatic chk_frame(input string tag, input int t0, input logic [15:0] bits,
                             input int nb, input int n);
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < n; c++)
                chk($sformatf("%s_bit%0d_c%0d", tag, b, c), txd_log[t0 + 1 + b*n + c], bits[b]);
        chk({tag, "_nodone"}, done_log[t0 + nb*n], 1'b0);
        chk({tag, "_done"},   done_log[t0 + 1 + nb*n], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, bad_r, bad_t;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // reset state
        run(3);
        chk("rst_txd",   TXD, 1'b1);
        chk("rst_busy",  tx_busy, 1'b0);
        chk("rst_done",  tx_done, 1'b0);
        chk("rst_ready", bus.tx_ready, 1'b0);
        PRESET = 1'b0;
        tx_en  = 1'b1;
        #1;
        chk("idle_ready", bus.tx_ready, 1'b1);

        // disabled: byte waiting but nothing is taken
        tx_en = 1'b0;
        clr();
        push(8'h99);
        run(50);
        bad_r = 0; bad_t = 0;
        for (int i = cyc - 50; i < cyc; i++) begin
            if (rdy_log[i] !== 1'b0) bad_r++;
            if (txd_log[i] !== 1'b1) bad_t++;
        end
        chk("dis_ready_cycles", bad_r, 0);
        chk("dis_txd_cycles", bad_t, 0);
        chk("dis_accepts", acc_q.size(), 0);
        fq.delete();
        upd();

        // basic 8N1, N=4, 0xA5
        baud_div = 3;
        tx_en = 1'b1;
        clr();
        push(8'hA5);
        run(60);
        chk("b1_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) begin
            t0 = acc_q[0];
            chk_frame("b1", t0, 16'b1101001010, 10, 4);
            chk("b1_busy_start", busy_log[t0 + 1], 1'b1);
            chk("b1_busy_end",   busy_log[t0 + 40], 1'b1);
            chk("b1_busy_fall",  busy_log[t0 + 41], 1'b0);
        end
        chk("b1_done_cnt", done_q.size(), 1);

        // even parity, N=1: 11-cycle frame, parity bit 0
        baud_div = 0;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        clr();
        push(8'hA5);
        run(20);
        chk("pe_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) chk_frame("pe", acc_q[0], 16'b10101001010, 11, 1);

        // odd parity, two stop bits: 12-cycle frame, parity bit 1
        parity_odd = 1'b1;
        two_stop = 1'b1;
        clr();
        push(8'hA5);
        run(20);
        chk("po_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) chk_frame("po", acc_q[0], 16'b111101001010, 12, 1);
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;

        // back-to-back 0x55, 0x0F with N=2
        baud_div = 1;
        clr();
        fq.push_back(8'h55);
        push(8'h0F);
        run(60);
        chk("bb_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            t0 = acc_q[0];
            t1 = acc_q[1];
            chk("bb_accept_gap", t1 - t0, 20);
            chk_frame("bb0", t0, 16'b1010101010, 10, 2);
            chk_frame("bb1", t1, 16'b1000011110, 10, 2);
            chk("bb_busy_hold", busy_log[t0 + 21], 1'b1);
        end
        chk("bb_done_cnt", done_q.size(), 2);
        if (done_q.size() >= 2) chk("bb_done_gap", done_q[1] - done_q[0], 20);

        // reset during data bit 3, then a clean frame
        baud_div = 3;
        clr();
        push(8'hA5);
        tick();
        chk("rm_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) begin
            t0 = acc_q[0];
            while (cyc < t0 + 17 && cyc < LOG) tick();
            chk("rm_in_data", busy_log[t0 + 17 - 1], 1'b1);
            PRESET = 1'b1;
            tick();
            PRESET = 1'b0;
            #1;
            chk("rm_txd",   TXD, 1'b1);
            chk("rm_busy",  tx_busy, 1'b0);
            chk("rm_ready", bus.tx_ready, 1'b1);
        end
        clr();
        push(8'h3C);
        run(50);
        chk("rm2_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) chk_frame("rm2", acc_q[0], 16'b1001111000, 10, 4);
        chk("rm2_done_cnt", done_q.size(), 1);

        // baud change then tx_en drop mid-frame
        baud_div = 3;
        clr();
        push(8'hA5);
        run(10);
        baud_div = 7;
        run(5);
        tx_en = 1'b0;
        push(8'h33);
        run(80);
        chk("mf_accepts", acc_q.size(), 1);
        if (acc_q.size() >= 1) chk_frame("mf", acc_q[0], 16'b1101001010, 10, 4);
        chk("mf_txd_idle", TXD, 1'b1);
        chk("mf_ready", bus.tx_ready, 1'b0);
        chk("mf_fifo_left", fq.size(), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit-side UART serializer fed by the APB-UART bridge's TX FIFO.
- Pops one byte at a time through a valid/ready handshake and drives the serial TXD line.
- Frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Bit timing comes from the bridge's BaudDiv register; frame format comes from Cntrl[3:0].

Parameters:
DATA_WIDTH, 8, data bits per frame.
BAUD_WIDTH, 20, width of baud divisor (matches BaudDiv[19:0]).

Ports:
PCLK  input  1  system clock; all logic on rising edge.
PRESET  input  1  reset; synchronous, active-high.
tx_en  input  1  Cntrl[0]; transmitter enable.
parity_en  input  1  Cntrl[1]; insert parity bit.
parity_odd  input  1  Cntrl[2]; 1 = odd parity, 0 = even parity.
two_stop  input  1  Cntrl[3]; 1 = two stop bits.
baud_div  input  BAUD_WIDTH  bit period minus one, in PCLK cycles.
tx_valid  input  1  TX FIFO not empty.
tx_data  input  DATA_WIDTH  TX FIFO head byte.
tx_ready  output  1  pop strobe to TX FIFO; byte accepted when tx_valid & tx_ready.
TXD  output  1  serial line, idle high.
tx_busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse at end of the final stop bit.

Behaviour:
- Reset (PRESET=1 at a PCLK edge): state IDLE, TXD=1, tx_busy=0, tx_done=0, counters cleared. Any frame in progress is aborted and its byte is lost.
- Bit period: N = baud_div+1 cycles. baud_div=0 gives 1 cycle per bit.
- Config sampling: baud_div, parity_en, parity_odd and two_stop are latched on the accept cycle. Later changes do not affect the frame in flight.
- tx_ready is combinational:
  - tx_ready = tx_en & (state==IDLE | (state==STOP & last cycle of last stop bit)).
  - tx_ready does not depend on tx_valid.
- Accept: on a cycle T with tx_valid & tx_ready, tx_data is latched into a shift register and parity is computed.
  - Even parity bit = XOR of data bits; odd parity bit = its inverse.
  - From edge T+1: state=START, TXD=0, tx_busy=1.
- FSM (baud counter loads N-1 on each bit entry and counts down; the bit ends when the counter reaches 0):
  - IDLE: TXD=1. On accept go to START.
  - START: TXD=0 for N cycles, then DATA with bit_idx=0.
  - DATA: TXD=shift[0] for N cycles per bit; shift right; bit_idx increments. After bit_idx=DATA_WIDTH-1, go to PARITY if parity_en, else STOP.
  - PARITY: TXD=parity bit for N cycles, then STOP.
  - STOP: TXD=1 for N cycles, or 2N if two_stop. At the end, assert tx_done for exactly one cycle (the edge after the last stop cycle), then:
    - go to START if a new byte was accepted on the last stop cycle (back-to-back, no idle gap);
    - otherwise go to IDLE.
- TXD is registered (glitch-free). tx_busy=1 in every state except IDLE.
- Frame length: N*(1+DATA_WIDTH+parity_en+1+two_stop) cycles.
- tx_en deasserted mid-frame: the current frame completes normally and no further byte is accepted.
- tx_valid low in IDLE: the block stays idle; TXD=1 and tx_ready stays asserted (if tx_en=1).
- Simultaneous end-of-frame and accept: tx_done pulses and the new START begins on the same edge.

Decomposition:
- Shared defines header (defines.vh):
  - UART_TX FSM state encodings (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - Cntrl bit indices (TX_EN=0, PARITY_EN=1, PARITY_ODD=2, TWO_STOP=3);
  - BAUD_WIDTH.
- One sub-module: uart_baud_gen.
  - Loadable down-counter; inputs load and period (BAUD_WIDTH bits); output bit_end pulse.
  - Reused later by the RX deserializer.

Test Plan:
- Basic frame: baud_div=3, 8N1, tx_data=0xA5 accepted at cycle 0.
  - TXD=0 over cycles 1-4.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each (cycles 5-36).
  - TXD=1 over cycles 37-40; tx_done pulse at edge 41; tx_busy falls at 41.
- Parity: 0xA5 with parity_en=1.
  - Even parity: parity bit=0; odd parity: parity bit=1.
  - Frame with baud_div=0 is 11 cycles; with two_stop=1 it is 12 cycles.
- Back-to-back: FIFO holds 0x55 then 0x0F, baud_div=1.
  - Second tx_ready&tx_valid occurs on the last stop cycle of the first frame.
  - TXD goes 1→0 with no extra idle cycle; 2 tx_done pulses, 20 cycles apart.
- Mid-frame changes: baud_div changed from 3 to 7 during the DATA state; then tx_en dropped.
  - Current frame keeps N=4 and completes.
  - No further accept; TXD stays 1.
- Reset mid-frame: PRESET asserted for 1 cycle during DATA bit 3.
  - The next edge gives TXD=1, tx_busy=0, state IDLE.
  - The following accepted byte transmits correctly.
- Disabled: tx_en=0 with tx_valid=1 for 50 cycles.
  - tx_ready=0 and TXD=1 throughout.
